// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 1042;  // 10 MHz / 9600 baud
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4,
    PARITY    = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side bundle: serial line in, byte, strobes and busy out.
// The parity_err signal exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport slave  (input rx, output data, data_valid, frame_err, busy, parity_err);
  modport master (output rx, input data, data_valid, frame_err, busy, parity_err);
`else
  modport slave  (input rx, output data, data_valid, frame_err, busy);
  modport master (output rx, input data, data_valid, frame_err, busy);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is selectable.
// No configuration macros.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-cycle data_valid / frame_err strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err strobe.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | counting to mid start bit, reject glitch if line high again
// DATA      | sampling 8 data bits LSB first at mid-bit
// PARITY    | sampling parity bit (parity build only)
// STOP      | sampling stop bit, issue data_valid / parity_err / frame_err
// WAIT_HIGH | after framing error, wait for line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = 11
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e            state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, cnt_nxt;
  logic [2:0]           bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 dv_q, dv_nxt;
  logic                 fe_q, fe_nxt;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt;
  logic                 pe_q, pe_nxt;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      clk_cnt <= cnt_nxt;
      bit_idx <= idx_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      dv_q    <= dv_nxt;
      fe_q    <= fe_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_nxt;
      pe_q    <= pe_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = data_q;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    pe_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (clk_cnt == MID_CNT) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt   = '0;
          par_nxt   = rx_s;
          state_nxt = STOP;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt == LAST_CNT) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bit != ^shift) begin
              pe_nxt = 1'b1;
            end else begin
              data_nxt = shift;
              dv_nxt   = 1'b1;
            end
`else
            data_nxt = shift;
            dv_nxt   = 1'b1;
`endif
          end else begin
            // framing error wins over parity; break line yields one strobe only
            fe_nxt    = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.frame_err  = fe_q;
  assign bus.busy       = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// Define UART_RX_PARITY_EN to exercise the even-parity variant.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk;
  logic rst_n;
  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(C), .CNT_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] dv_q[$];
  int         dv_cyc[$];
  int         fe_cnt, pe_cnt, both_cnt, busy_run, busy_max;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (u_if.data_valid) begin
      dv_q.push_back(u_if.data);
      dv_cyc.push_back(cyc);
    end
    if (u_if.frame_err) fe_cnt++;
    if (u_if.data_valid && u_if.frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (u_if.parity_err) pe_cnt++;
    if (u_if.parity_err && (u_if.data_valid || u_if.frame_err)) both_cnt++;
`endif
    if (u_if.busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    dv_q.delete();
    dv_cyc.delete();
    fe_cnt   = 0;
    pe_cnt   = 0;
    busy_max = 0;
  endtask

  task automatic idle(input int n);
    u_if.rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // line-level frame, LSB first: start, 8 data, [parity], stop
  function automatic logic [11:0] frame(input logic [7:0] b, input logic par, input logic stop);
    logic [11:0] f;
`ifdef UART_RX_PARITY_EN
    f = {1'b0, stop, par, b, 1'b0};
`else
    f = {2'b00, stop, b, 1'b0};
    if (par) f = f;
`endif
    return f;
  endfunction

  task automatic send_bits(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      u_if.rx = bits[i];
      repeat (C) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bits(frame(b, ^b, stop), FRAME_BITS);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  int         t0;

  initial begin
    rst_n     = 1'b0;
    u_if.rx   = 1'b1;
    fe_cnt    = 0;
    pe_cnt    = 0;
    both_cnt  = 0;
    busy_run  = 0;
    busy_max  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_data", u_if.data, 8'h00);
    chk_eq("rst_valid", u_if.data_valid, 1'b0);
    chk_eq("rst_ferr", u_if.frame_err, 1'b0);
    chk_eq("rst_busy", u_if.busy, 1'b0);
`ifdef UART_RX_PARITY_EN
    chk_eq("rst_perr", u_if.parity_err, 1'b0);
`endif
    rst_n = 1'b1;
    idle(4);

    // single frame, latency from line edge
    clear_mon();
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    chk_eq("a5_busy_after", u_if.busy, 1'b0);
    idle(C);
    chk_eq("a5_count", dv_q.size(), 1);
    if (dv_q.size() == 1) begin
      chk_eq("a5_data", dv_q[0], 8'hA5);
      chk_eq("a5_latency", dv_cyc[0] - t0, ((2 * FRAME_BITS - 1) * C) / 2 + 3);
    end
    chk_eq("a5_ferr", fe_cnt, 0);

    // back-to-back frames
    clear_mon();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(C);
    chk_eq("b2b_count", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      chk_eq("b2b_data0", dv_q[0], 8'h00);
      chk_eq("b2b_data1", dv_q[1], 8'hFF);
      chk_eq("b2b_gap", dv_cyc[1] - dv_cyc[0], FRAME_BITS * C);
    end
    last_good = 8'hFF;

    // short low glitch
    clear_mon();
    u_if.rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * C);
    chk_eq("glitch_strobes", dv_q.size() + fe_cnt + pe_cnt, 0);
    chk_eq("glitch_busy_le10", busy_max <= 10, 1'b1);
    chk_eq("glitch_idle", u_if.busy, 1'b0);

    // framing error with held-low break
    clear_mon();
    send_byte(8'h3C, 1'b0);
    u_if.rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk_eq("brk_busy", u_if.busy, 1'b1);
    idle(C);
    chk_eq("brk_ferr_cnt", fe_cnt, 1);
    chk_eq("brk_no_valid", dv_q.size(), 0);
    chk_eq("brk_data_kept", u_if.data, last_good);
    send_byte(8'h81, 1'b1);
    idle(C);
    chk_eq("brk_next_cnt", dv_q.size(), 1);
    chk_eq("brk_next_data", u_if.data, 8'h81);

    // reset during bit 4
    clear_mon();
    send_bits(frame(8'h5A, 1'b0, 1'b1), 5);
    repeat (C / 2) @(posedge clk);
    #1;
    chk_eq("mid_busy_pre", u_if.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_data", u_if.data, 8'h00);
    chk_eq("mid_rst_busy", u_if.busy, 1'b0);
    chk_eq("mid_rst_strb", {u_if.data_valid, u_if.frame_err}, 2'b00);
    u_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_byte(8'h5A, 1'b1);
    idle(C);
    chk_eq("mid_next_cnt", dv_q.size(), 1);
    chk_eq("mid_next_data", u_if.data, 8'h5A);

`ifdef UART_RX_PARITY_EN
    // even parity: bit must equal XOR of data bits (0x07 -> 1)
    clear_mon();
    last_good = u_if.data;
    send_bits(frame(8'h07, ~(^8'h07), 1'b1), FRAME_BITS);
    idle(C);
    chk_eq("par_bad_perr", pe_cnt, 1);
    chk_eq("par_bad_nodv", dv_q.size(), 0);
    chk_eq("par_bad_data", u_if.data, last_good);
    send_bits(frame(8'h07, ^8'h07, 1'b1), FRAME_BITS);
    idle(C);
    chk_eq("par_ok_perr", pe_cnt, 1);
    chk_eq("par_ok_data", u_if.data, 8'h07);
    clear_mon();
    send_bits(frame(8'h07, ~(^8'h07), 1'b0), FRAME_BITS);
    idle(C);
    chk_eq("par_fe_prio", {fe_cnt[3:0], pe_cnt[3:0]}, 8'h10);
`endif

    // random bytes with random idle gaps
    clear_mon();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      idle($urandom_range(0, C));
    end
    idle(2 * C);
    chk_eq("rnd_count", dv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dv_q.size(); i++)
      chk_eq($sformatf("rnd_data%0d", i), dv_q[i], exp_q[i]);
    chk_eq("rnd_ferr", fe_cnt, 0);
    chk_eq("strobe_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
